// File: rtl/ddr3_dly_seq_pkg.sv
// Shared types for the DDR3 IOD delay-line sequencer.
// Holds the FSM state encoding and the request opcodes.
package ddr3_dly_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETUP,
        S_PULSE,
        S_SETTLE,
        S_DONE
    } state_t;

    localparam logic [1:0] OP_LOAD      = 2'b00;
    localparam logic [1:0] OP_STEP_UP   = 2'b01;
    localparam logic [1:0] OP_STEP_DOWN = 2'b10;

    function automatic logic [3:0] lane_onehot(input logic [1:0] l);
        return 4'b0001 << l;
    endfunction

endpackage

// File: rtl/ddr3_dly_line_seq_if.sv
// Request/response handshake between the training FSM and the
// delay-line sequencer.
interface ddr3_dly_line_seq_if #(
    parameter int TAP_W = 8
);
    logic             REQ_VALID;
    logic             REQ_READY;
    logic [1:0]       REQ_LANE;
    logic [1:0]       REQ_OP;
    logic [TAP_W-1:0] REQ_COUNT;
    logic             DONE;
    logic             ERR;

    modport master (
        output REQ_VALID, REQ_LANE, REQ_OP, REQ_COUNT,
        input  REQ_READY, DONE, ERR
    );

    modport slave (
        input  REQ_VALID, REQ_LANE, REQ_OP, REQ_COUNT,
        output REQ_READY, DONE, ERR
    );
endinterface

// File: rtl/ddr3_dly_seq_tap_bank.sv
// Per-lane tracked tap counters and "loaded since reset" flags.
// Only the lane selected by lane is ever modified.
module ddr3_dly_seq_tap_bank #(
    parameter int NUM_LANES = 3,
    parameter int TAP_W     = 8,
    parameter int LOAD_TAP  = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [1:0]                 lane,
    input  logic                       load,
    input  logic                       inc,
    input  logic                       dec,
    output logic [NUM_LANES*TAP_W-1:0] tap_value,
    output logic [NUM_LANES-1:0]       tap_known,
    output logic [TAP_W-1:0]           cur_tap
);
    logic [TAP_W-1:0] taps [NUM_LANES];

    // Update the addressed lane's counter and known flag
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                taps[i] <= '0;
            end
            tap_known <= '0;
        end else begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (lane == i[1:0]) begin
                    if (load) begin
                        taps[i]      <= TAP_W'(LOAD_TAP);
                        tap_known[i] <= 1'b1;
                    end else if (inc) begin
                        taps[i] <= taps[i] + 1'b1;
                    end else if (dec) begin
                        taps[i] <= taps[i] - 1'b1;
                    end
                end
            end
        end
    end

    // Select the addressed lane's current tap for range checks
    always_comb begin
        cur_tap = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (lane == i[1:0]) cur_tap = taps[i];
        end
    end

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_flat
        assign tap_value[g*TAP_W +: TAP_W] = taps[g];
    end

endmodule

// File: rtl/ddr3_dly_line_seq.sv
// Sequencer turning tap-adjust requests into spaced LOAD/MOVE/DIRECTION
// pulses on one IOD delay-line lane at a time.
module ddr3_dly_line_seq
    import ddr3_dly_seq_pkg::*;
#(
    parameter int NUM_LANES     = 3,
    parameter int TAP_W         = 8,
    parameter int MAX_TAP       = 255,
    parameter int LOAD_TAP      = 1,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                       FAB_CLK,
    input  logic                       SYNC_RST,
    ddr3_dly_line_seq_if.slave         req,
    output logic [NUM_LANES-1:0]       DELAY_LINE_LOAD,
    output logic [NUM_LANES-1:0]       DELAY_LINE_MOVE,
    output logic [NUM_LANES-1:0]       DELAY_LINE_DIRECTION,
    input  logic [NUM_LANES-1:0]       DELAY_LINE_OUT_OF_RANGE,
    output logic [NUM_LANES*TAP_W-1:0] TAP_VALUE,
    output logic [NUM_LANES-1:0]       TAP_KNOWN
);
    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);

    state_t           state_q, state_d;
    logic [1:0]       lane_q, lane_d;
    logic [1:0]       op_q, op_d;
    logic [TAP_W-1:0] rem_q, rem_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_d;
    logic             tap_load, tap_inc, tap_dec;
    logic [TAP_W-1:0] cur_tap;
    logic             req_known, lane_ok, oor_sel, up;
    logic [3:0]       oh_d;

    ddr3_dly_seq_tap_bank #(
        .NUM_LANES (NUM_LANES),
        .TAP_W     (TAP_W),
        .LOAD_TAP  (LOAD_TAP)
    ) u_bank (
        .clk       (FAB_CLK),
        .rst       (SYNC_RST),
        .lane      (lane_q),
        .load      (tap_load),
        .inc       (tap_inc),
        .dec       (tap_dec),
        .tap_value (TAP_VALUE),
        .tap_known (TAP_KNOWN),
        .cur_tap   (cur_tap)
    );

    // Per-lane lookups for the incoming lane and the latched lane
    always_comb begin
        req_known = 1'b0;
        oor_sel   = 1'b0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (req.REQ_LANE == i[1:0]) req_known = TAP_KNOWN[i];
            if (lane_q == i[1:0]) oor_sel = DELAY_LINE_OUT_OF_RANGE[i];
        end
    end

    assign lane_ok = int'(req.REQ_LANE) < NUM_LANES;
    assign up      = (op_q == OP_STEP_UP);
    assign oh_d    = lane_onehot(lane_d);

    // Next-state, request latching and tap-bank strobes
    always_comb begin
        state_d  = state_q;
        lane_d   = lane_q;
        op_d     = op_q;
        rem_d    = rem_q;
        cnt_d    = cnt_q;
        err_d    = 1'b0;
        tap_load = 1'b0;
        tap_inc  = 1'b0;
        tap_dec  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (req.REQ_VALID && req.REQ_READY) begin
                    lane_d = req.REQ_LANE;
                    op_d   = req.REQ_OP;
                    rem_d  = req.REQ_COUNT;
                    if (!lane_ok || req.REQ_OP == 2'b11) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else if (req.REQ_OP == OP_LOAD) begin
                        state_d = S_LOAD;
                    end else if (!req_known) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else if (req.REQ_COUNT == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_SETUP;
                    end
                end
            end
            S_LOAD: begin
                tap_load = 1'b1;
                cnt_d    = CNT_W'(SETTLE_CYCLES - 1);
                state_d  = S_SETTLE;
            end
            S_SETUP: begin
                if ((up && cur_tap == TAP_W'(MAX_TAP)) ||
                    (!up && cur_tap == '0)) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    state_d = S_PULSE;
                end
            end
            S_PULSE: begin
                cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
                state_d = S_SETTLE;
            end
            S_SETTLE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (op_q == OP_LOAD) begin
                    state_d = S_DONE;
                end else if (oor_sel) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    tap_inc = up;
                    tap_dec = !up;
                    rem_d   = rem_q - 1'b1;
                    state_d = (rem_q == TAP_W'(1)) ? S_DONE : S_SETUP;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State register and registered outputs decoded from next state
    always_ff @(posedge FAB_CLK) begin
        if (SYNC_RST) begin
            state_q              <= S_IDLE;
            lane_q               <= '0;
            op_q                 <= '0;
            rem_q                <= '0;
            cnt_q                <= '0;
            req.REQ_READY        <= 1'b0;
            req.DONE             <= 1'b0;
            req.ERR              <= 1'b0;
            DELAY_LINE_LOAD      <= '0;
            DELAY_LINE_MOVE      <= '0;
            DELAY_LINE_DIRECTION <= '0;
        end else begin
            state_q              <= state_d;
            lane_q               <= lane_d;
            op_q                 <= op_d;
            rem_q                <= rem_d;
            cnt_q                <= cnt_d;
            req.REQ_READY        <= (state_d == S_IDLE);
            req.DONE             <= (state_d == S_DONE);
            req.ERR              <= (state_d == S_DONE) && err_d;
            DELAY_LINE_LOAD      <= (state_d == S_LOAD) ?
                                    oh_d[NUM_LANES-1:0] : '0;
            DELAY_LINE_MOVE      <= (state_d == S_PULSE) ?
                                    oh_d[NUM_LANES-1:0] : '0;
            DELAY_LINE_DIRECTION <= ((state_d == S_SETUP ||
                                      state_d == S_PULSE ||
                                      state_d == S_SETTLE) &&
                                     op_d == OP_STEP_UP) ?
                                    oh_d[NUM_LANES-1:0] : '0;
        end
    end

endmodule

// File: tb/tb_ddr3_dly_line_seq.sv
// Scoreboard bench for the delay-line sequencer: directed requests push
// expected completions, a negedge monitor checks pulses and DONE.
module tb_ddr3_dly_line_seq;
    import ddr3_dly_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  dl_load, dl_move, dl_dir;
    logic [2:0]  oor = 3'b000;
    logic [23:0] tap_value;
    logic [2:0]  tap_known;
    int          cyc = 0;

    int n_cmp = 0;
    int n_bad = 0;

    ddr3_dly_line_seq_if #(.TAP_W(8)) bus ();

    ddr3_dly_line_seq dut (
        .FAB_CLK                 (clk),
        .SYNC_RST                (rst),
        .req                     (bus),
        .DELAY_LINE_LOAD         (dl_load),
        .DELAY_LINE_MOVE         (dl_move),
        .DELAY_LINE_DIRECTION    (dl_dir),
        .DELAY_LINE_OUT_OF_RANGE (oor),
        .TAP_VALUE               (tap_value),
        .TAP_KNOWN               (tap_known)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int       t_done;
        int       t_first;
        int       lane;
        bit       err;
        int       nload;
        int       nmove;
        bit       dir;
        bit       chk_tap;
        int       tap;
        bit [2:0] known;
    } exp_t;

    exp_t q[$];

    int nl = 0, nm = 0, first_pc = -1, stray = 0, dirbad = 0;

    task automatic chk(input string nm_s, input int act, input int want);
        n_cmp++;
        if (act != want) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d (cyc %0d)",
                     nm_s, act, want, cyc);
        end
    endtask

    task automatic clr_mon();
        nl = 0; nm = 0; first_pc = -1; stray = 0; dirbad = 0;
    endtask

    // Monitor: tally pulses per request, score each DONE against the queue
    always @(negedge clk) begin : mon
        int   ln;
        exp_t e;
        ln = (q.size() != 0) ? q[0].lane : -1;
        for (int i = 0; i < 3; i++) begin
            if (i != ln && (dl_load[i] || dl_move[i] || dl_dir[i]))
                stray++;
        end
        if ((|dl_load) || (|dl_move)) begin
            if (first_pc < 0) first_pc = cyc;
            if (ln >= 0 && ln < 3) begin
                nl += int'(dl_load[ln]);
                nm += int'(dl_move[ln]);
                if (dl_move[ln] && dl_dir[ln] != q[0].dir) dirbad++;
            end
        end
        if (bus.DONE === 1'b1) begin
            if (q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                e = q.pop_front();
                chk("done_time", cyc, e.t_done);
                chk("err", int'(bus.ERR), int'(e.err));
                chk("load_pulses", nl, e.nload);
                chk("move_pulses", nm, e.nmove);
                chk("first_pulse", first_pc, e.t_first);
                chk("stray_lane_bits", stray, 0);
                chk("direction", dirbad, 0);
                chk("tap_known", int'(tap_known), int'(e.known));
                if (e.chk_tap)
                    chk("tap_value", int'(tap_value[e.lane*8 +: 8]), e.tap);
            end
            clr_mon();
        end
    end

    // Issue one request; kd/kf are offsets from the acceptance edge
    task automatic issue(input int lane, input int op, input int cnt,
                         input int kd, input int kf, input bit err,
                         input int nld, input int nmv, input bit dir,
                         input int tap, input bit [2:0] known,
                         output int t0);
        exp_t e;
        int   n;
        @(negedge clk);
        bus.REQ_VALID = 1'b1;
        bus.REQ_LANE  = 2'(lane);
        bus.REQ_OP    = 2'(op);
        bus.REQ_COUNT = 8'(cnt);
        n = 0;
        while (bus.REQ_READY !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("ready_timeout", 0, 1);
        t0        = cyc + 1;
        e.t_done  = t0 + kd - 1;
        e.t_first = (kf < 0) ? -1 : t0 + kf - 1;
        e.lane    = lane;
        e.err     = err;
        e.nload   = nld;
        e.nmove   = nmv;
        e.dir     = dir;
        e.chk_tap = (lane < 3);
        e.tap     = tap;
        e.known   = known;
        q.push_back(e);
        @(negedge clk);
        bus.REQ_VALID = 1'b0;
        chk("ready_drop", int'(bus.REQ_READY), 0);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            chk("done_timeout", q.size(), 0);
            q.delete();
        end
    endtask

    initial begin : stim
        int t0;
        bus.REQ_VALID = 1'b0;
        bus.REQ_LANE  = '0;
        bus.REQ_OP    = '0;
        bus.REQ_COUNT = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", int'(bus.REQ_READY), 0);
        chk("rst_done", int'(bus.DONE), 0);
        chk("rst_tap", int'(tap_value), 0);
        chk("rst_known", int'(tap_known), 0);
        chk("rst_pulses", int'({dl_load, dl_move, dl_dir}), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", int'(bus.REQ_READY), 1);

        // Step on an unloaded lane, bad lane, reserved op
        issue(0, 2, 1, 1, -1, 1, 0, 0, 0, 0, 3'b000, t0);
        wait_idle();
        issue(3, 0, 0, 1, -1, 1, 0, 0, 0, 0, 3'b000, t0);
        wait_idle();
        issue(0, 3, 1, 1, -1, 1, 0, 0, 0, 0, 3'b000, t0);
        wait_idle();

        // LOAD lane 1, then three steps up, then a zero-count step
        issue(1, 0, 0, 6, 1, 0, 1, 0, 0, 1, 3'b010, t0);
        wait_idle();
        issue(1, 1, 3, 19, 2, 0, 0, 3, 1, 4, 3'b010, t0);
        wait_idle();
        issue(1, 1, 0, 1, -1, 0, 0, 0, 1, 4, 3'b010, t0);
        wait_idle();

        // LOAD lane 0, step down twice: second step underflows
        issue(0, 0, 0, 6, 1, 0, 1, 0, 0, 1, 3'b011, t0);
        wait_idle();
        issue(0, 2, 2, 8, 2, 1, 0, 1, 0, 0, 3'b011, t0);
        wait_idle();

        // LOAD lane 2, step up 5 with range flag raised after 2nd MOVE
        issue(2, 0, 0, 6, 1, 0, 1, 0, 0, 1, 3'b111, t0);
        wait_idle();
        oor = 3'b001;
        issue(2, 1, 5, 13, 2, 1, 0, 2, 1, 2, 3'b111, t0);
        while (cyc < t0 + 8) @(negedge clk);
        oor = 3'b101;
        wait_idle();
        oor = 3'b000;

        // Reset in the middle of the first SETTLE of a 4-step request
        issue(1, 1, 4, 25, 2, 0, 0, 4, 1, 8, 3'b111, t0);
        while (cyc < t0 + 3) @(negedge clk);
        chk("dir_before_rst", int'(dl_dir), 3'b010);
        rst = 1'b1;
        q.delete();
        @(negedge clk);
        clr_mon();
        chk("midrst_ready", int'(bus.REQ_READY), 0);
        chk("midrst_done_err", int'({bus.DONE, bus.ERR}), 0);
        chk("midrst_pulses", int'({dl_load, dl_move, dl_dir}), 0);
        chk("midrst_tap", int'(tap_value), 0);
        chk("midrst_known", int'(tap_known), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_midrst", int'(bus.REQ_READY), 1);
        repeat (8) @(negedge clk);

        // Lane 1 is unknown again after reset
        issue(1, 1, 2, 1, -1, 1, 0, 0, 1, 0, 3'b000, t0);
        wait_idle();
        repeat (4) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ddr3_dly_line_seq.md
# ddr3_dly_line_seq

Sequencer for the dynamic output delay lines of the DDR3 address/command IOD lanes (bank-address group and similar). It accepts one tap-adjust request at a time from the training/calibration logic and converts it into correctly spaced DELAY_LINE_LOAD, MOVE and DIRECTION pulses on the target lane. It tracks the current tap per lane, reports completion and error, and sits in the FAB_CLK domain between the DDR PHY training FSM and the IOD wrapper.

## Interface
- NUM_LANES, 3: number of IOD lanes driven (1–4).
- TAP_W, 8: tap counter width.
- MAX_TAP, 255: highest legal tap value.
- LOAD_TAP, 1: tap value a LOAD places the lane at.
- SETTLE_CYCLES, 4: wait cycles after each LOAD/MOVE pulse (≥1).

Ports:
- FAB_CLK  in  1  sole clock, rising edge.
- SYNC_RST  in  1  reset; one clock; reset is synchronous and active-high.
- REQ_VALID  in  1  request present.
- REQ_READY  out  1  high only in IDLE and not in reset.
- REQ_LANE  in  2  target lane index.
- REQ_OP  in  2  00 LOAD, 01 STEP_UP, 10 STEP_DOWN, 11 reserved (error).
- REQ_COUNT  in  TAP_W  step count for STEP ops; ignored for LOAD.
- DONE  out  1  one-cycle completion pulse.
- ERR  out  1  valid with DONE; 1 = request aborted or rejected.
- DELAY_LINE_LOAD  out  NUM_LANES  per-lane load pulse.
- DELAY_LINE_MOVE  out  NUM_LANES  per-lane move pulse.
- DELAY_LINE_DIRECTION  out  NUM_LANES  per-lane direction, 1 = increment.
- DELAY_LINE_OUT_OF_RANGE  in  NUM_LANES  per-lane range flag from IOD.
- TAP_VALUE  out  NUM_LANES*TAP_W  tracked tap, lane 0 in LSBs.
- TAP_KNOWN  out  NUM_LANES  lane has been LOADed since reset.

## Operation
- States: IDLE, LOAD, SETUP, PULSE, SETTLE, DONE.
- Accept on REQ_VALID & REQ_READY; latch lane, op, count; remaining = REQ_COUNT.
- Immediate rejects (IDLE→DONE, ERR=1, no pulses): lane ≥ NUM_LANES; op 11; STEP on lane with TAP_KNOWN=0.
- STEP with count 0: IDLE→DONE, ERR=0, no pulses.
- LOAD: LOAD state drives DELAY_LINE_LOAD[lane]=1 one cycle; TAP_VALUE[lane]=LOAD_TAP, TAP_KNOWN[lane]=1 at that edge; then SETTLE; then DONE, ERR=0.
- STEP: SETUP drives DIRECTION[lane] (held through PULSE and SETTLE). If the step would exceed MAX_TAP or go below 0: SETUP→DONE, ERR=1, no pulse. Else PULSE: MOVE[lane]=1 one cycle. SETTLE counts SETTLE_CYCLES; on its last cycle sample OUT_OF_RANGE[lane]: if 1 → DONE, ERR=1, tap unchanged; else tap ±1, remaining−1, then SETUP if remaining>0 else DONE, ERR=0.
- DONE: DONE=1 one cycle, return to IDLE.
- Only the addressed lane's LOAD/MOVE/DIRECTION bits ever toggle; others stay 0.

## Timing
- Reset values: REQ_READY 0 during SYNC_RST, 1 the cycle after; DONE, ERR, LOAD, MOVE, DIRECTION all 0; TAP_VALUE 0; TAP_KNOWN 0; state IDLE.
- SYNC_RST mid-operation: abandons request on the next edge; no DONE issued; pulses in flight drop immediately.
- All outputs registered. Acceptance edge = t0.
- LOAD: LOAD high cycle t0+1; DONE cycle t0+2+SETTLE_CYCLES.
- STEP of N: per step 2+SETTLE_CYCLES cycles (SETUP, PULSE, SETTLE); first MOVE at t0+2; DONE at t0+1+N*(2+SETTLE_CYCLES).
- Rejects and count-0: DONE at t0+1.
- REQ_READY drops the cycle after acceptance, returns the cycle after DONE; back-to-back request accepted no earlier than DONE+1.
- OUT_OF_RANGE is sampled only on the last SETTLE cycle; values at other times are ignored.

## Structure
- Package ddr3_dly_seq_pkg: state enum, REQ_OP encodings (OP_LOAD, OP_STEP_UP, OP_STEP_DOWN).
- Sub-module ddr3_dly_seq_tap_bank: per-lane tap counters and TAP_KNOWN bits with load/inc/dec ports. The FSM and settle counter stay in the top.

## Test plan
- Reset, then LOAD lane 1 → LOAD[1] high at t0+1 only; DONE at t0+6, ERR=0; TAP_VALUE lane1=1, TAP_KNOWN=3'b010.
- After LOAD, STEP_UP lane 1 count 3 → three MOVE[1] pulses at t0+2, t0+8, t0+14; DIRECTION[1]=1; DONE at t0+19; tap=4.
- STEP_DOWN lane 0 before any LOAD → DONE+ERR at t0+1, no pulses; STEP_DOWN count 2 at tap 1 → one MOVE, then ERR with tap 0.
- STEP_UP lane 2 count 5 with OUT_OF_RANGE[2] forced high after the 2nd MOVE → DONE+ERR after the 2nd SETTLE; tap advanced by 1 only.
- Assert SYNC_RST during SETTLE of a 4-step request → no DONE; all outputs and TAP_KNOWN 0 next cycle; REQ_READY 1 the cycle after reset releases.
- REQ_LANE=3 or REQ_OP=11 → DONE+ERR at t0+1; STEP count 0 → DONE, ERR=0, no pulses.
